// File: rtl/montgomery_reduce_ws.sv
// -----------------------------------------------------------------------------
// montgomery_reduce_ws
//
// Word-serial Montgomery reducer. Takes a 2s-block product T (LSB block first)
// and returns T * R^-1 mod N with R = 2^(REGISTER_SIZE * NUM_BLOCKS). The
// modulus N lives in an on-chip RAM and is loaded block by block; only the
// single-word constant n0' = -N^-1 mod 2^W is needed. All arithmetic runs
// through one shared W x W multiply-accumulate, one block per cycle.
//
// Optional feature macro: MONT_REDUCE_LAZY_EN
//   defined   : no final subtraction; streams t[s..2s-1] followed by an extra
//               block holding the top carry bit X in bit 0 (result in [0, 2N)).
//   undefined : fully reduced s-block result.
//
// Ports
//   clk_in, rst_n_in      clock (rising edge), asynchronous active-low reset
//   n_load_valid_in       one N block presented (LSB block first), IDLE only
//   n_block_in            N block
//   n0_prime_in           -N^-1 mod 2^W, held stable while busy_out = 1
//   n_loaded_out          all s blocks of N have been written
//   valid_in/ready_out    T block handshake
//   T_block_in            T block, LSB block first
//   valid_out/ready_in    result block handshake
//   data_block_out        result block, LSB block first
//   final_out             marks the last result block
//   busy_out              block is in any state other than IDLE
// -----------------------------------------------------------------------------
module montgomery_reduce_ws #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     n_load_valid_in,
    input  logic [REGISTER_SIZE-1:0] n_block_in,
    input  logic [REGISTER_SIZE-1:0] n0_prime_in,
    output logic                     n_loaded_out,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [REGISTER_SIZE-1:0] T_block_in,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [REGISTER_SIZE-1:0] data_block_out,
    output logic                     final_out,
    output logic                     busy_out
);

    localparam int W   = REGISTER_SIZE;
    localparam int W2  = 2 * REGISTER_SIZE;
    localparam int S   = NUM_BLOCKS;
    localparam int AW  = $clog2(2 * S);
    localparam int NAW = (S > 1) ? $clog2(S) : 1;
    localparam int CW  = $clog2(2 * S + 1);

    localparam logic [CW-1:0] S_C  = CW'(S);
    localparam logic [CW-1:0] S2_C = CW'(2 * S);
`ifdef MONT_REDUCE_LAZY_EN
    localparam logic [CW-1:0] NOUT_C = CW'(S + 1);
`else
    localparam logic [CW-1:0] NOUT_C = CW'(S);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_T,
        ST_MCALC,
        ST_MAC,
        ST_CARRY,
        ST_OUTPUT
`ifndef MONT_REDUCE_LAZY_EN
        , ST_SUB
`endif
    } state_e;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic            ph_q, ph_d;              // MCALC: 0 = fetch t[i], 1 = form m
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [CW-1:0]   n_ptr_q, n_ptr_d;
    logic            n_loaded_q, n_loaded_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    c_q, c_d;
    logic            x_q, x_d;
`ifndef MONT_REDUCE_LAZY_EN
    logic            borrow_q, borrow_d;
    logic            sel_diff_q, sel_diff_d;
`else
    logic            rd_is_x_q, rd_is_x_d;    // read slot holds the X block
`endif
    logic [CW-1:0]   fetch_q, fetch_d;        // next result block to read
    logic [CW-1:0]   load_idx_q, load_idx_d;  // next result block to present
    logic            rd_valid_q, rd_valid_d;  // RAM read register holds a block
    logic            valid_out_q, valid_out_d;
    logic [W-1:0]    data_q, data_d;
    logic            final_q, final_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    // RAM ports
    logic            t_we, t_re, n_we, n_re;
    logic [AW-1:0]   t_waddr, t_raddr;
    logic [W-1:0]    t_wdata;
    logic [NAW-1:0]  n_waddr, n_raddr;
    logic [W-1:0]    t_mem [2*S];
    logic [W-1:0]    n_mem [S];
    logic [W-1:0]    t_rd_q, n_rd_q;

    // Datapath intermediates
    logic [W2-1:0]   mac_sum;
    logic [W:0]      carry_sum;
`ifndef MONT_REDUCE_LAZY_EN
    logic [W:0]      sub_diff;
`endif
    logic            out_load, fetch;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        ph_d        = ph_q;
        i_d         = i_q;
        j_d         = j_q;
        n_ptr_d     = n_ptr_q;
        n_loaded_d  = n_loaded_q;
        m_d         = m_q;
        c_d         = c_q;
        x_d         = x_q;
`ifndef MONT_REDUCE_LAZY_EN
        borrow_d    = borrow_q;
        sel_diff_d  = sel_diff_q;
        sub_diff    = '0;
`else
        rd_is_x_d   = rd_is_x_q;
`endif
        fetch_d     = fetch_q;
        load_idx_d  = load_idx_q;
        rd_valid_d  = rd_valid_q;
        valid_out_d = valid_out_q;
        data_d      = data_q;
        final_d     = final_q;
        t_we        = 1'b0;
        t_waddr     = '0;
        t_wdata     = '0;
        t_re        = 1'b0;
        t_raddr     = '0;
        n_we        = 1'b0;
        n_waddr     = '0;
        n_re        = 1'b0;
        n_raddr     = '0;
        mac_sum     = '0;
        carry_sum   = '0;
        out_load    = 1'b0;
        fetch       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A T handshake wins over a simultaneous N beat.
                if (valid_in && ready_q) begin
                    t_we    = 1'b1;
                    t_waddr = '0;
                    t_wdata = T_block_in;
                    j_d     = CW'(1);
                    x_d     = 1'b0;
                    state_d = ST_LOAD_T;
                end else if (n_load_valid_in) begin
                    n_we = 1'b1;
                    if (n_loaded_q) begin
                        // Reload restarts at N[0].
                        n_waddr    = '0;
                        n_ptr_d    = CW'(1);
                        n_loaded_d = 1'b0;
                    end else begin
                        n_waddr = NAW'(n_ptr_q);
                        if (n_ptr_q == S_C - CW'(1)) begin
                            n_ptr_d    = '0;
                            n_loaded_d = 1'b1;
                        end else begin
                            n_ptr_d = n_ptr_q + CW'(1);
                        end
                    end
                end
            end

            ST_LOAD_T: begin
                if (valid_in) begin
                    t_we    = 1'b1;
                    t_waddr = AW'(j_q);
                    t_wdata = T_block_in;
                    if (j_q == S2_C - CW'(1)) begin
                        i_d     = '0;
                        j_d     = '0;
                        ph_d    = 1'b0;
                        state_d = ST_MCALC;
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
            end

            ST_MCALC: begin
                if (!ph_q) begin
                    t_re    = 1'b1;
                    t_raddr = AW'(i_q);
                    ph_d    = 1'b1;
                end else begin
                    m_d     = W'(t_rd_q * n0_prime_in);
                    c_d     = '0;
                    j_d     = '0;
                    ph_d    = 1'b0;
                    state_d = ST_MAC;
                end
            end

            // Cycle j issues reads of t[i+j] and N[j] and retires block j-1.
            // The extra cycle j = s fetches t[i+s] for the CARRY step.
            ST_MAC: begin
                t_re    = 1'b1;
                t_raddr = AW'(i_q + j_q);
                if (j_q != S_C) begin
                    n_re    = 1'b1;
                    n_raddr = NAW'(j_q);
                end
                if (j_q != '0) begin
                    mac_sum = W2'(t_rd_q) + W2'(m_q) * W2'(n_rd_q) + W2'(c_q);
                    t_we    = 1'b1;
                    t_waddr = AW'(i_q + j_q - CW'(1));
                    t_wdata = mac_sum[W-1:0];
                    c_d     = mac_sum[W2-1:W];
                end
                if (j_q == S_C) begin
                    state_d = ST_CARRY;
                end else begin
                    j_d = j_q + CW'(1);
                end
            end

            // X holds the carry out of t[i+s]; it lands on t[i+s+1], which is
            // exactly the word the next iteration's CARRY step adds into.
            ST_CARRY: begin
                carry_sum = {1'b0, t_rd_q} + {1'b0, c_q} + (W+1)'(x_q);
                t_we      = 1'b1;
                t_waddr   = AW'(i_q + S_C);
                t_wdata   = carry_sum[W-1:0];
                x_d       = carry_sum[W];
                if (i_q == S_C - CW'(1)) begin
                    j_d = '0;
`ifdef MONT_REDUCE_LAZY_EN
                    fetch_d    = '0;
                    load_idx_d = '0;
                    rd_valid_d = 1'b0;
                    state_d    = ST_OUTPUT;
`else
                    borrow_d = 1'b0;
                    state_d  = ST_SUB;
`endif
                end else begin
                    i_d     = i_q + CW'(1);
                    ph_d    = 1'b0;
                    state_d = ST_MCALC;
                end
            end

`ifndef MONT_REDUCE_LAZY_EN
            // Difference t[s..2s-1] - N goes into the free lower half t[0..s-1].
            ST_SUB: begin
                if (j_q != S_C) begin
                    t_re    = 1'b1;
                    t_raddr = AW'(S_C + j_q);
                    n_re    = 1'b1;
                    n_raddr = NAW'(j_q);
                end
                if (j_q != '0) begin
                    sub_diff = {1'b0, t_rd_q} - {1'b0, n_rd_q} - (W+1)'(borrow_q);
                    t_we     = 1'b1;
                    t_waddr  = AW'(j_q - CW'(1));
                    t_wdata  = sub_diff[W-1:0];
                    borrow_d = sub_diff[W];
                end
                if (j_q == S_C) begin
                    // Keep the difference if the true sum (with X) is >= N.
                    sel_diff_d = x_q | ~sub_diff[W];
                    fetch_d    = '0;
                    load_idx_d = '0;
                    rd_valid_d = 1'b0;
                    state_d    = ST_OUTPUT;
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
`endif

            // Two-deep pipeline: the RAM read register is a holding slot in
            // front of the output register, so a stalled consumer never loses
            // a block and an unstalled one sees one block per cycle.
            ST_OUTPUT: begin
                out_load = rd_valid_q && (!valid_out_q || ready_in);
                fetch    = (fetch_q != NOUT_C) && (!rd_valid_q || out_load);
                if (fetch) begin
`ifdef MONT_REDUCE_LAZY_EN
                    if (fetch_q == S_C) begin
                        rd_is_x_d = 1'b1;
                    end else begin
                        rd_is_x_d = 1'b0;
                        t_re      = 1'b1;
                        t_raddr   = AW'(S_C + fetch_q);
                    end
`else
                    t_re    = 1'b1;
                    t_raddr = sel_diff_q ? AW'(fetch_q) : AW'(S_C + fetch_q);
`endif
                    fetch_d = fetch_q + CW'(1);
                end

                if (fetch) begin
                    rd_valid_d = 1'b1;
                end else if (out_load) begin
                    rd_valid_d = 1'b0;
                end

                if (out_load) begin
                    valid_out_d = 1'b1;
`ifdef MONT_REDUCE_LAZY_EN
                    data_d      = rd_is_x_q ? W'(x_q) : t_rd_q;
`else
                    data_d      = t_rd_q;
`endif
                    final_d     = (load_idx_q == NOUT_C - CW'(1));
                    load_idx_d  = load_idx_q + CW'(1);
                end else if (valid_out_q && ready_in) begin
                    valid_out_d = 1'b0;
                    final_d     = 1'b0;
                end

                if (valid_out_q && ready_in && final_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        ready_d = n_loaded_d && ((state_d == ST_IDLE) || (state_d == ST_LOAD_T));
        busy_d  = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            ph_q        <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            n_ptr_q     <= '0;
            n_loaded_q  <= 1'b0;
            m_q         <= '0;
            c_q         <= '0;
            x_q         <= 1'b0;
`ifndef MONT_REDUCE_LAZY_EN
            borrow_q    <= 1'b0;
            sel_diff_q  <= 1'b0;
`else
            rd_is_x_q   <= 1'b0;
`endif
            fetch_q     <= '0;
            load_idx_q  <= '0;
            rd_valid_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_q      <= '0;
            final_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            i_q         <= i_d;
            j_q         <= j_d;
            n_ptr_q     <= n_ptr_d;
            n_loaded_q  <= n_loaded_d;
            m_q         <= m_d;
            c_q         <= c_d;
            x_q         <= x_d;
`ifndef MONT_REDUCE_LAZY_EN
            borrow_q    <= borrow_d;
            sel_diff_q  <= sel_diff_d;
`else
            rd_is_x_q   <= rd_is_x_d;
`endif
            fetch_q     <= fetch_d;
            load_idx_q  <= load_idx_d;
            rd_valid_q  <= rd_valid_d;
            valid_out_q <= valid_out_d;
            data_q      <= data_d;
            final_q     <= final_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // RAMs: one write and one registered read port each
    // ------------------------------------------------------------------
    // NOTE: RAM contents and their read registers are deliberately not reset;
    // every location is written before it is read, and a reset port would
    // prevent mapping onto block RAM.
    always_ff @(posedge clk_in) begin
        if (t_we) t_mem[t_waddr] <= t_wdata;
        if (t_re) t_rd_q <= t_mem[t_raddr];
    end

    always_ff @(posedge clk_in) begin
        if (n_we) n_mem[n_waddr] <= n_block_in;
        if (n_re) n_rd_q <= n_mem[n_raddr];
    end

    assign n_loaded_out   = n_loaded_q;
    assign ready_out      = ready_q;
    assign valid_out      = valid_out_q;
    assign data_block_out = data_q;
    assign final_out      = final_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_montgomery_reduce_ws.sv
// -----------------------------------------------------------------------------
// tb_montgomery_reduce_ws
//
// Bench for montgomery_reduce_ws with W = 8, s = 2, N = 0xF1A7, n0' = 0xE9.
// Expected results come from plain modular arithmetic: T * R^-1 mod N with
// R^-1 found by search over [1, N).
// -----------------------------------------------------------------------------
module tb_montgomery_reduce_ws;

    localparam int W = 8;
    localparam int S = 2;
    localparam logic [15:0] N_VAL   = 16'hF1A7;
    localparam logic [7:0]  N0P_VAL = 8'hE9;
    localparam int LAT_MAX = S * (S + 4) + S + 8;

    logic         clk_in;
    logic         rst_n_in;
    logic         n_load_valid_in;
    logic [W-1:0] n_block_in;
    logic [W-1:0] n0_prime_in;
    logic         n_loaded_out;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] T_block_in;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] data_block_out;
    logic         final_out;
    logic         busy_out;

    int n_cmp  = 0;
    int n_fail = 0;
    longint unsigned rinv;

    montgomery_reduce_ws #(.REGISTER_SIZE(W), .NUM_BLOCKS(S)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .n_load_valid_in(n_load_valid_in),
        .n_block_in     (n_block_in),
        .n0_prime_in    (n0_prime_in),
        .n_loaded_out   (n_loaded_out),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .T_block_in     (T_block_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .data_block_out (data_block_out),
        .final_out      (final_out),
        .busy_out       (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] t;
        logic [15:0] res;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mont(input logic [31:0] t);
        longint unsigned tm;
        tm = 64'(t) % 64'(N_VAL);
        return 16'((tm * rinv) % 64'(N_VAL));
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    64'(ready_out),      0);
        check({tag, "_valid"},    64'(valid_out),      0);
        check({tag, "_data"},     64'(data_block_out), 0);
        check({tag, "_final"},    64'(final_out),      0);
        check({tag, "_busy"},     64'(busy_out),       0);
        check({tag, "_n_loaded"}, 64'(n_loaded_out),   0);
    endtask

    task automatic load_n();
        logic [15:0] nv;
        nv = N_VAL;
        for (int b = 0; b < S; b++) begin
            n_load_valid_in = 1'b1;
            n_block_in      = nv[8*b +: 8];
            tick();
        end
        n_load_valid_in = 1'b0;
    endtask

    task automatic send_t(input logic [31:0] t_val);
        int wait_c;
        for (int b = 0; b < 2 * S; b++) begin
            valid_in   = 1'b1;
            T_block_in = t_val[8*b +: 8];
            wait_c     = 0;
            while (!ready_out && wait_c < 100) begin
                tick();
                wait_c++;
            end
            if (wait_c >= 100) check("t_ready_timeout", 64'(ready_out), 1);
            tick();
        end
        valid_in = 1'b0;
    endtask

    // Collects s result blocks. stall_mode 0: ready_in always 1;
    // stall_mode 1: ready_in high one cycle in three.
    task automatic recv_result(input int stall_mode, output logic [15:0] res);
        int          got, cyc, first_cyc, hs0, hs1, unstable;
        logic        held_v, held_f;
        logic [7:0]  held_d;
        got = 0; cyc = 0; first_cyc = 9999; hs0 = 0; hs1 = 0;
        unstable = 0; held_v = 1'b0; held_f = 1'b0; held_d = '0; res = '0;
        while (got < S && cyc < 300) begin
            ready_in = (stall_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (held_v && (!valid_out || data_block_out !== held_d || final_out !== held_f))
                unstable++;
            if (valid_out && first_cyc == 9999) first_cyc = cyc;
            if (valid_out && ready_in) begin
                res[8*got +: 8] = data_block_out;
                check("final_flag", 64'(final_out), 64'(got == S - 1));
                if (got == 0) hs0 = cyc; else hs1 = cyc;
                got++;
                held_v = 1'b0;
            end else if (valid_out) begin
                held_v = 1'b1;
                held_d = data_block_out;
                held_f = final_out;
            end else begin
                held_v = 1'b0;
            end
            tick();
            cyc++;
        end
        ready_in = 1'b0;
        check("blocks_received", 64'(got), 64'(S));
        check("latency_in_budget", 64'(first_cyc <= LAT_MAX), 1);
        if (stall_mode == 0) check("back_to_back", 64'(hs1 - hs0), 1);
        else                 check("stall_stable", 64'(unstable), 0);
        check("ready_after_final", 64'(ready_out), 1);
        check("no_extra_block", 64'(valid_out), 0);
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] res;
        logic [31:0] tv;
        int          accepted;

        vecs[0] = '{t: 32'h0000_0000, res: 16'h0000};
        vecs[1] = '{t: 32'h0001_0000, res: 16'h0001};
        vecs[2] = '{t: 32'hF1A6_0000, res: 16'hF1A6};
        vecs[3] = '{t: 32'h0002_0000, res: 16'h0002};
        vecs[4] = '{t: 32'h1234_0000, res: 16'h1234};
        vecs[5] = '{t: 32'h0000_F1A7, res: 16'h0000};
        vecs[6] = '{t: 32'h0001_E34E, res: 16'h0000};

        rinv = 0;
        for (longint unsigned x = 1; x < 64'(N_VAL); x++) begin
            if (((x << 16) % 64'(N_VAL)) == 1) begin
                rinv = x;
                break;
            end
        end

        rst_n_in        = 1'b1;
        n_load_valid_in = 1'b0;
        n_block_in      = '0;
        n0_prime_in     = N0P_VAL;
        valid_in        = 1'b0;
        T_block_in      = '0;
        ready_in        = 1'b0;
        #2 rst_n_in = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n_in = 1'b1;
        tick();

        // T beats before N is loaded are ignored.
        valid_in = 1'b1;
        tick();
        check("no_ready_before_n", 64'(ready_out), 0);
        check("idle_before_n", 64'(busy_out), 0);
        valid_in = 1'b0;

        load_n();
        check("n_loaded", 64'(n_loaded_out), 1);

        // Directed table
        foreach (vecs[k]) begin
            send_t(vecs[k].t);
            recv_result(0, res);
            check("vector_result", 64'(res), 64'(vecs[k].res));
        end

        // Reload N: first beat clears n_loaded_out, last beat sets it again.
        n_load_valid_in = 1'b1;
        n_block_in      = 8'hA7;
        tick();
        check("reload_clears_n_loaded", 64'(n_loaded_out), 0);
        n_block_in = 8'hF1;
        tick();
        n_load_valid_in = 1'b0;
        check("reload_sets_n_loaded", 64'(n_loaded_out), 1);

        // T beats offered while busy must not be taken; then a stalled drain.
        tv = 32'hF1A6_FFFF;
        send_t(tv);
        valid_in   = 1'b1;
        T_block_in = 8'h5A;
        accepted   = 0;
        repeat (6) begin
            if (ready_out) accepted++;
            tick();
        end
        check("busy_during_op", 64'(busy_out), 1);
        check("busy_no_accept", 64'(accepted), 0);
        valid_in = 1'b0;
        recv_result(1, res);
        check("stalled_result", 64'(res), 64'(ref_mont(tv)));

        // Random T < N*R against the arithmetic model
        for (int k = 0; k < 1000; k++) begin
            tv = $urandom % 32'hF1A7_0000;
            send_t(tv);
            recv_result((k % 4 == 0) ? 1 : 0, res);
            check("random_result", 64'(res), 64'(ref_mont(tv)));
        end

        // Asynchronous reset in the middle of MAC
        send_t(32'h1234_5678);
        repeat (3) tick();
        check("busy_before_reset", 64'(busy_out), 1);
        #2 rst_n_in = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        rst_n_in = 1'b1;
        tick();
        load_n();
        send_t(32'h0001_0000);
        recv_result(0, res);
        check("after_reset_result", 64'(res), 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/montgomery_reduce_ws.md
# montgomery_reduce_ws

Word-serial Montgomery reducer: it accepts a 2s-block product T and returns T·R⁻¹ mod N, with R = 2^(REGISTER_SIZE·s). N is held internally, and only the single-word constant n0' = −N⁻¹ mod 2^REGISTER_SIZE is required, not a full-width k. It is the parametrised successor to the streaming reducer in the modular-exponentiation datapath. Differences from that reducer: one shared W×W multiply-accumulate, N stored on-chip, and ready/valid backpressure on both streams.

## Interface
Parameters:
- REGISTER_SIZE, 32, block width W in bits.
- NUM_BLOCKS, 128, blocks in N (s). The input T is 2s blocks; the output is s blocks. Minimum value 2.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- n_load_valid_in  in  1  one N block is presented this cycle (LSB block first).
- n_block_in  in  W  N block.
- n0_prime_in  in  W  −N⁻¹ mod 2^W; must be stable while busy_out = 1.
- n_loaded_out  out  1  all s blocks of N have been written.
- valid_in  in  1  T block valid.
- ready_out  out  1  block accepts a T block.
- T_block_in  in  W  T block, LSB block first.
- valid_out  out  1  result block valid.
- ready_in  in  1  downstream accepts a result block.
- data_block_out  out  W  result block, LSB block first.
- final_out  out  1  high with the last result block.
- busy_out  out  1  any state other than IDLE.

## Operation
- Storage: N RAM of s×W bits; work RAM t of 2s×W bits.
- Registers: carry word C, extra carry bit X, multiplier word m.

States and transitions:
- IDLE
  - An n_load_valid_in beat writes N[ptr] and increments ptr.
  - When ptr reaches s, n_loaded_out is set.
  - An n_load_valid_in beat while n_loaded_out = 1 clears n_loaded_out and restarts loading at N[0].
  - The first accepted T beat moves to LOAD_T.
- LOAD_T
  - Writes t[0..2s−1].
  - After the 2s-th beat, moves to MCALC with i = 0.
- MCALC
  - m = (t[i]·n0') mod 2^W.
  - C = 0.
  - Moves to MAC with j = 0.
- MAC
  - Computes {C, t[i+j]} = t[i+j] + m·N[j] + C. The sum is at most 2^(2W)−1.
  - After j = s−1, moves to CARRY.
- CARRY
  - {X, t[i+s]} = t[i+s] + C + X.
  - When i < s−1: increments i and returns to MCALC.
  - Otherwise moves to SUB.
- SUB
  - For j = 0..s−1: {borrow, t[j]} = t[s+j] − N[j] − borrow, with initial borrow = 0.
  - Then computes sel_diff = X | ~borrow.
  - Moves to OUTPUT.
- OUTPUT
  - Streams t[j] if sel_diff is set, otherwise t[s+j], for j = 0..s−1.
  - After the final handshake, returns to IDLE.

Rules:
- ready_out = n_loaded_out and (state is IDLE or LOAD_T).
- T beats are ignored while n_loaded_out = 0.
- n_load_valid_in is ignored outside IDLE.
- Input contract: N is odd and T < N·R. Under this contract the result before subtraction is less than 2N, so one subtraction suffices.

## Timing
- Reset values:
  - ready_out = 0, valid_out = 0, data_block_out = 0, final_out = 0, busy_out = 0, n_loaded_out = 0.
  - State IDLE; all pointers 0; C = 0; X = 0.
  - RAM contents are undefined. N must be reloaded after every reset.
- Reset mid-operation takes effect immediately. The block returns to IDLE and the partially processed T is discarded.
- RAM reads have 1-cycle latency. MAC and SUB are pipelined to one block per cycle.
- Per-operation cycle budget after the last T beat:
  - Each i-iteration: ≤ s+4 cycles.
  - SUB: ≤ s+3 cycles.
  - First valid_out: ≤ s(s+4) + s + 8 cycles.
- Output handshake:
  - valid_out holds, and data_block_out and final_out are stable, until ready_in = 1.
  - With ready_in held at 1, the output produces one block per cycle, s consecutive blocks.
- ready_out returns to 1 on the cycle after the final output handshake.

## Configuration
- MONT_REDUCE_LAZY_EN
  - When defined: the SUB state is removed, and OUTPUT streams t[s..2s−1] unconditionally. The result is in [0, 2N) and is congruent to T·R⁻¹. X is presented on data_block_out's sideband final_out cycle as bit 0 of an extra (s+1)-th block, so s+1 blocks are output and final_out marks the (s+1)-th block.
  - When undefined: fully reduced s-block output, as described in Operation.

## Test plan
All scenarios use W = 8, s = 2, N = 0xF1A7, n0' = 0xE9.
- Load N, T = 0x0000_0000 -> output blocks 0x00, 0x00; final_out high on the second block.
- T = 0x0001_0000 (= R) -> output 0x0001 (blocks 0x01, 0x00).
- T = N·R − R = 0xF1A6_0000 -> output 0xF1A6.
- 1000 random T < N·R -> output = T·R⁻¹ mod N per the golden model. This includes cases with X = 1.
- ready_in toggled with a 1-in-3 duty during OUTPUT -> no block is lost or duplicated, and data is stable while stalled. A T beat presented during busy_out = 1 is not accepted.
- rst_n_in asserted low during MAC -> all outputs are immediately at reset values and n_loaded_out = 0. After reloading N and sending T = R, output = 0x0001.
